// File: rtl/clock_sel_ctrl.sv
// clock_sel_ctrl: validates clock-source requests and drives the registered
// select into a glitch-free clock switch, holding off changes during settle.
//
// Ports:
//   clk, rst_clk_n          control clock, async active-low reset
//   req_valid/req_ready     request handshake, req_sel = requested source
//   scan_mode               freezes selection and refuses requests
//   clk_sel                 registered select to the clock switch
//   busy                    high while the settle window is running
//   switch_done             1-cycle pulse: request completed or no-op
//   err_invalid             1-cycle pulse: request rejected
//   lock_set, locked        only when CLK_SEL_LOCK_EN is defined
//
// Optional feature macro: CLK_SEL_LOCK_EN (sticky lock refusing switches).

module clock_sel_ctrl #(
    parameter int SEL_W      = 2,
    parameter int NUM_SRC    = 3,
    parameter int DEF_SEL    = 1,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_clk_n,
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
    output logic             req_ready,
    input  logic             scan_mode,
`ifdef CLK_SEL_LOCK_EN
    input  logic             lock_set,
    output logic             locked,
`endif
    output logic [SEL_W-1:0] clk_sel,
    output logic             busy,
    output logic             switch_done,
    output logic             err_invalid
);

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_e;

    localparam logic [SEL_W-1:0] SEL_RST  = SEL_W'(DEF_SEL);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W:0]   NSRC     = (SEL_W + 1)'(NUM_SRC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             accept;
    logic             bad_sel;
    logic             lock_on;

`ifdef CLK_SEL_LOCK_EN
    logic locked_q;

    // Sticky until reset; a switch already settling is left to finish.
    always_ff @(posedge clk or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            locked_q <= 1'b0;
        end else if (lock_set) begin
            locked_q <= 1'b1;
        end
    end

    assign locked  = locked_q;
    assign lock_on = locked_q;
`else
    assign lock_on = 1'b0;
`endif

    // Gated by reset so the requester never sees ready while held in reset.
    assign req_ready = rst_clk_n && (state_q == IDLE) && !scan_mode;
    assign accept    = req_valid && req_ready;
    assign bad_sel   = ({1'b0, req_sel} >= NSRC);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bad_sel || lock_on) begin
                        err_d = 1'b1;
                    end else if (req_sel == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        sel_d   = req_sel;
                        state_d = SETTLE;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SETTLE);
    end

    always_ff @(posedge clk or negedge rst_clk_n) begin
        if (!rst_clk_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign clk_sel     = sel_q;
    assign busy        = busy_q;
    assign switch_done = done_q;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_clock_sel_ctrl.sv
// Directed testbench for clock_sel_ctrl.
// Uses default parameters (NUM_SRC=3, DEF_SEL=1, SETTLE_CYC=16).

module tb_clock_sel_ctrl;

    logic       clk;
    logic       rst_clk_n;
    logic       req_valid;
    logic [1:0] req_sel;
    logic       req_ready;
    logic       scan_mode;
    logic [1:0] clk_sel;
    logic       busy;
    logic       switch_done;
    logic       err_invalid;
`ifdef CLK_SEL_LOCK_EN
    logic       lock_set;
    logic       locked;
`endif

    int checks = 0;
    int errors = 0;
    int done_cnt;

    clock_sel_ctrl dut (
        .clk         (clk),
        .rst_clk_n   (rst_clk_n),
        .req_valid   (req_valid),
        .req_sel     (req_sel),
        .req_ready   (req_ready),
        .scan_mode   (scan_mode),
`ifdef CLK_SEL_LOCK_EN
        .lock_set    (lock_set),
        .locked      (locked),
`endif
        .clk_sel     (clk_sel),
        .busy        (busy),
        .switch_done (switch_done),
        .err_invalid (err_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (switch_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        chk("excl", {31'd0, switch_done & err_invalid}, 32'd0);
    endtask

    initial begin
        rst_clk_n = 1'b0;
        req_valid = 1'b0;
        req_sel   = 2'd0;
        scan_mode = 1'b0;
        done_cnt  = 0;
`ifdef CLK_SEL_LOCK_EN
        lock_set  = 1'b0;
`endif
        #12;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_sel", {30'd0, clk_sel}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, switch_done}, 32'd0);
        chk("rst_err", {31'd0, err_invalid}, 32'd0);
        rst_clk_n = 1'b1;
        step();
        chk("rel_ready", {31'd0, req_ready}, 32'd1);
        chk("rel_sel", {30'd0, clk_sel}, 32'd1);

        // Illegal source code
        req_valid = 1'b1;
        req_sel   = 2'd3;
        step();
        req_valid = 1'b0;
        chk("inv_err", {31'd0, err_invalid}, 32'd1);
        chk("inv_sel", {30'd0, clk_sel}, 32'd1);
        chk("inv_busy", {31'd0, busy}, 32'd0);
        chk("inv_done", {31'd0, switch_done}, 32'd0);
        step();
        chk("inv_err_pulse", {31'd0, err_invalid}, 32'd0);

        // No-op request
        req_valid = 1'b1;
        req_sel   = 2'd1;
        step();
        req_valid = 1'b0;
        chk("noop_done", {31'd0, switch_done}, 32'd1);
        chk("noop_busy", {31'd0, busy}, 32'd0);
        chk("noop_sel", {30'd0, clk_sel}, 32'd1);
        step();
        chk("noop_done_pulse", {31'd0, switch_done}, 32'd0);
        chk("noop_busy2", {31'd0, busy}, 32'd0);

        // Switch 1->2 with a held request for 0 behind it
        done_cnt  = 0;
        req_valid = 1'b1;
        req_sel   = 2'd2;
        chk("sw_ready", {31'd0, req_ready}, 32'd1);
        step();
        chk("sw_sel", {30'd0, clk_sel}, 32'd2);
        chk("sw_busy", {31'd0, busy}, 32'd1);
        req_sel = 2'd0;
        for (int i = 0; i < 15; i++) begin
            step();
            chk("sw_busy_hold", {31'd0, busy}, 32'd1);
            chk("sw_ready_lo", {31'd0, req_ready}, 32'd0);
            chk("sw_done_lo", {31'd0, switch_done}, 32'd0);
            chk("sw_sel_hold", {30'd0, clk_sel}, 32'd2);
        end
        step();
        chk("sw_done", {31'd0, switch_done}, 32'd1);
        chk("sw_busy_end", {31'd0, busy}, 32'd0);
        chk("sw_ready_idle", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk("b2b_sel", {30'd0, clk_sel}, 32'd0);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 15; i++) step();
        chk("b2b_pre_done", {31'd0, switch_done}, 32'd0);
        step();
        chk("b2b_done", {31'd0, switch_done}, 32'd1);
        step();
        chk("b2b_done_cnt", done_cnt, 32'd2);

        // scan_mode blocks requests
        scan_mode = 1'b1;
        req_valid = 1'b1;
        req_sel   = 2'd1;
        for (int i = 0; i < 50; i++) begin
            step();
            chk("scan_ready", {31'd0, req_ready}, 32'd0);
            chk("scan_sel", {30'd0, clk_sel}, 32'd0);
        end
        scan_mode = 1'b0;
        #1;
        chk("scan_drop_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk("scan_drop_sel", {30'd0, clk_sel}, 32'd1);
        chk("scan_drop_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 17; i++) step();
        chk("scan_idle", {31'd0, busy}, 32'd0);

        // Reset mid-settle at count 5
        req_valid = 1'b1;
        req_sel   = 2'd2;
        step();
        req_valid = 1'b0;
        chk("rs_sel", {30'd0, clk_sel}, 32'd2);
        for (int i = 0; i < 10; i++) step();
        rst_clk_n = 1'b0;
        #1;
        chk("rs_async_sel", {30'd0, clk_sel}, 32'd1);
        chk("rs_async_busy", {31'd0, busy}, 32'd0);
        chk("rs_async_ready", {31'd0, req_ready}, 32'd0);
        step();
        rst_clk_n = 1'b1;
        step();
        chk("rs_rel_ready", {31'd0, req_ready}, 32'd1);

`ifdef CLK_SEL_LOCK_EN
        chk("lk_rst", {31'd0, locked}, 32'd0);
        lock_set = 1'b1;
        step();
        lock_set = 1'b0;
        chk("lk_set", {31'd0, locked}, 32'd1);
        req_valid = 1'b1;
        req_sel   = 2'd2;
        chk("lk_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        chk("lk_err", {31'd0, err_invalid}, 32'd1);
        chk("lk_sel", {30'd0, clk_sel}, 32'd1);
        chk("lk_busy", {31'd0, busy}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
